// File: rtl/strap_rst_ctrl.sv
// Reset/strap controller: glitch-filtered N-source reset, stretched system reset, debounced strap lock.
// Optional macro STRAP_RST_CAUSE_EN adds reset-cause capture outputs (rst_cause_o, por_o).
module strap_rst_ctrl #(
  parameter int unsigned NumRstSrc         = 3,
  parameter int unsigned NumStraps         = 2,
  parameter int unsigned FilterCycles      = 8,
  parameter int unsigned StretchCycles     = 32,
  parameter int unsigned StrapStableCycles = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumRstSrc-1:0] rst_req_ni,
  input  logic [NumStraps-1:0] strap_i,
  output logic                 rst_sys_no,
  output logic [NumStraps-1:0] strap_o,
  output logic                 strap_valid_o,
  output logic                 dbg_spi_sel_o,
  output logic                 busy_o
`ifdef STRAP_RST_CAUSE_EN
  ,
  output logic [NumRstSrc-1:0] rst_cause_o,
  output logic                 por_o
`endif
);

  localparam int unsigned FiltW = $clog2(FilterCycles + 1);
  localparam int unsigned StrW  = $clog2(StretchCycles + 1);
  localparam int unsigned StbW  = $clog2(StrapStableCycles + 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STRETCH = 2'd1,
    ST_SAMPLE  = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  logic [NumRstSrc-1:0] r_req_s1, r_req_s2;
  logic [NumStraps-1:0] r_strap_s1, r_strap_s2, r_strap_prev;
  logic [NumRstSrc-1:0] w_req_hit;
  logic                 w_req_any;

  state_e               r_state, w_state_next;
  logic [StrW-1:0]      r_str_cnt, w_str_cnt_next;
  logic [StbW-1:0]      r_stb_cnt, w_stb_cnt_next;
  logic                 w_latch;

  logic                 r_rst_sys_n, r_strap_valid, r_dbg_spi_sel, r_busy;
  logic [NumStraps-1:0] r_strap;

  // Two-flop synchronisers; requests idle high, straps idle low
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req_s1     <= '1;
      r_req_s2     <= '1;
      r_strap_s1   <= '0;
      r_strap_s2   <= '0;
      r_strap_prev <= '0;
    end else begin
      r_req_s1     <= rst_req_ni;
      r_req_s2     <= r_req_s1;
      r_strap_s1   <= strap_i;
      r_strap_s2   <= r_strap_s1;
      r_strap_prev <= r_strap_s2;
    end
  end

  for (genvar g = 0; g < NumRstSrc; g++) begin : g_filt
    logic [FiltW-1:0] r_filt_cnt;

    always_ff @(posedge clk_i) begin
      if (rst_i || r_req_s2[g]) begin
        r_filt_cnt <= '0;
      end else if (!w_req_hit[g]) begin
        r_filt_cnt <= r_filt_cnt + FiltW'(1);
      end
    end

    assign w_req_hit[g] = (r_filt_cnt == FiltW'(FilterCycles));
  end

  assign w_req_any = |w_req_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_ASSERT;
      r_str_cnt <= '0;
      r_stb_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_str_cnt <= w_str_cnt_next;
      r_stb_cnt <= w_stb_cnt_next;
    end
  end

  // A live request outranks every transition, including leaving ASSERT
  always_comb begin
    w_state_next   = r_state;
    w_str_cnt_next = '0;
    w_stb_cnt_next = '0;
    w_latch        = 1'b0;
    case (r_state)
      ST_ASSERT: begin
        if (!w_req_any) w_state_next = ST_STRETCH;
      end
      ST_STRETCH: begin
        if (w_req_any) begin
          w_str_cnt_next = '0;
        end else if (r_str_cnt == StrW'(StretchCycles - 1)) begin
          w_state_next = ST_SAMPLE;
        end else begin
          w_str_cnt_next = r_str_cnt + StrW'(1);
        end
      end
      ST_SAMPLE: begin
        if (w_req_any) begin
          w_state_next = ST_ASSERT;
        end else if (r_strap_s2 != r_strap_prev) begin
          w_stb_cnt_next = '0;
        end else if (r_stb_cnt == StbW'(StrapStableCycles - 1)) begin
          w_latch      = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_stb_cnt_next = r_stb_cnt + StbW'(1);
        end
      end
      ST_RUN: begin
        if (w_req_any) w_state_next = ST_ASSERT;
      end
      default: w_state_next = ST_ASSERT;
    endcase
  end

  // Outputs follow the next state so rst_sys_no moves on the transition edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rst_sys_n   <= 1'b0;
      r_strap       <= '0;
      r_strap_valid <= 1'b0;
      r_dbg_spi_sel <= 1'b0;
      r_busy        <= 1'b1;
    end else begin
      r_rst_sys_n   <= (w_state_next == ST_RUN);
      r_strap_valid <= (w_state_next == ST_RUN);
      r_busy        <= (w_state_next != ST_RUN);
      r_dbg_spi_sel <= (w_state_next == ST_RUN) && (w_latch ? r_strap_s2[0] : r_strap[0]);
      if (w_latch) r_strap <= r_strap_s2;
    end
  end

  assign rst_sys_no    = r_rst_sys_n;
  assign strap_o       = r_strap;
  assign strap_valid_o = r_strap_valid;
  assign dbg_spi_sel_o = r_dbg_spi_sel;
  assign busy_o        = r_busy;

`ifdef STRAP_RST_CAUSE_EN
  logic [NumRstSrc-1:0] r_rst_cause;
  logic                 r_por;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rst_cause <= '0;
      r_por       <= 1'b1;
    end else if ((r_state != ST_ASSERT) && (w_state_next == ST_ASSERT)) begin
      r_rst_cause <= w_req_hit;
      r_por       <= 1'b0;
    end
  end

  assign rst_cause_o = r_rst_cause;
  assign por_o       = r_por;
`endif

endmodule

// File: tb/tb_strap_rst_ctrl.sv
// Self-checking bench for strap_rst_ctrl: directed scenarios plus randomized pads against a timeline model.
module tb_strap_rst_ctrl;

  localparam int NSRC    = 3;
  localparam int NSTR    = 2;
  localparam int FILT    = 8;
  localparam int STRETCH = 32;
  localparam int STABLE  = 16;

  localparam int M_HOLD    = 0;
  localparam int M_STRETCH = 1;
  localparam int M_SAMPLE  = 2;
  localparam int M_RUN     = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] req_n;
  logic [NSTR-1:0] strap;
  logic            rst_sys_n;
  logic [NSTR-1:0] strap_out;
  logic            strap_valid;
  logic            dbg_spi_sel;
  logic            busy;
`ifdef STRAP_RST_CAUSE_EN
  logic [NSRC-1:0] rst_cause;
  logic            por;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  strap_rst_ctrl #(
    .NumRstSrc(NSRC), .NumStraps(NSTR), .FilterCycles(FILT),
    .StretchCycles(STRETCH), .StrapStableCycles(STABLE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rst_req_ni(req_n), .strap_i(strap),
    .rst_sys_no(rst_sys_n), .strap_o(strap_out), .strap_valid_o(strap_valid),
    .dbg_spi_sel_o(dbg_spi_sel), .busy_o(busy)
`ifdef STRAP_RST_CAUSE_EN
    , .rst_cause_o(rst_cause), .por_o(por)
`endif
  );

  always #5 clk = ~clk;

  // Reference: pad delay lines, low-run lengths, and timestamps of the last restart mark
  int              m_cyc;
  int              m_mode;
  int              m_mark;
  int              m_low_run [NSRC];
  logic [NSRC-1:0] m_req_s1, m_req_s2;
  logic [NSTR-1:0] m_strap_s1, m_strap_s2, m_strap_prev, m_strap_lat;
  logic [NSRC-1:0] m_cause;
  logic            m_por;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [NSRC-1:0] hits;
    m_cyc++;
    if (rst) begin
      m_mode = M_HOLD; m_mark = m_cyc;
      for (int i = 0; i < NSRC; i++) m_low_run[i] = 0;
      m_req_s1 = '1; m_req_s2 = '1;
      m_strap_s1 = '0; m_strap_s2 = '0; m_strap_prev = '0; m_strap_lat = '0;
      m_cause = '0; m_por = 1'b1;
    end else begin
      for (int i = 0; i < NSRC; i++) hits[i] = (m_low_run[i] == FILT);
      case (m_mode)
        M_HOLD: if (hits == '0) begin m_mode = M_STRETCH; m_mark = m_cyc; end
        M_STRETCH: begin
          if (hits != '0) m_mark = m_cyc;
          else if (m_cyc - m_mark == STRETCH) begin m_mode = M_SAMPLE; m_mark = m_cyc; end
        end
        M_SAMPLE: begin
          if (hits != '0) begin m_mode = M_HOLD; m_cause = hits; m_por = 1'b0; end
          else if (m_strap_s2 != m_strap_prev) m_mark = m_cyc;
          else if (m_cyc - m_mark == STABLE) begin m_mode = M_RUN; m_strap_lat = m_strap_s2; end
        end
        default: if (hits != '0) begin m_mode = M_HOLD; m_cause = hits; m_por = 1'b0; end
      endcase
      for (int i = 0; i < NSRC; i++) begin
        if (m_req_s2[i]) m_low_run[i] = 0;
        else if (m_low_run[i] < FILT) m_low_run[i]++;
      end
      m_strap_prev = m_strap_s2; m_strap_s2 = m_strap_s1; m_strap_s1 = strap;
      m_req_s2 = m_req_s1; m_req_s1 = req_n;
    end
  endtask

  // One clock: advance the model with the inputs the DUT just sampled, then compare
  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    chk("rst_sys_no", 32'(rst_sys_n), 32'(m_mode == M_RUN));
    chk("busy_o", 32'(busy), 32'(m_mode != M_RUN));
    chk("strap_valid_o", 32'(strap_valid), 32'(m_mode == M_RUN));
    chk("strap_o", 32'(strap_out), 32'(m_strap_lat));
    chk("dbg_spi_sel_o", 32'(dbg_spi_sel), 32'((m_mode == M_RUN) && m_strap_lat[0]));
`ifdef STRAP_RST_CAUSE_EN
    chk("rst_cause_o", 32'(rst_cause), 32'(m_cause));
    chk("por_o", 32'(por), 32'(m_por));
`endif
  endtask

  task automatic wait_rst(input logic lvl, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (rst_sys_n !== lvl && n < budget);
  endtask

  initial begin
    int n;
    int bad;
    int pulse_left [NSRC];
    rst = 1'b1; req_n = '1; strap = 2'b01;
    m_cyc = 0;

    // Power-on
    repeat (4) step();
    chk("por_rst_busy", 32'(busy), 32'd1);
    chk("por_rst_sysn", 32'(rst_sys_n), 32'd0);
    rst = 1'b0;
    wait_rst(1'b1, 200, n);
    chk("por_latency", 32'(n), 32'd49);
    chk("por_strap", 32'(strap_out), 32'h1);
    chk("por_dbg_sel", 32'(dbg_spi_sel), 32'd1);
    chk("por_busy", 32'(busy), 32'd0);

    // 7-cycle glitch is rejected
    bad = 0;
    req_n[1] = 1'b0;
    repeat (7) begin step(); if (rst_sys_n !== 1'b1) bad++; end
    req_n[1] = 1'b1;
    repeat (20) begin step(); if (rst_sys_n !== 1'b1) bad++; end
    chk("glitch7_drops", 32'(bad), 32'd0);

    // 8-cycle request is accepted
    req_n[1] = 1'b0;
    n = 0;
    do begin
      step();
      n++;
      if (n == 8) req_n[1] = 1'b1;
    end while (rst_sys_n !== 1'b0 && n < 40);
    req_n[1] = 1'b1;
    chk("glitch8_latency", 32'(n), 32'd11);
    wait_rst(1'b1, 200, n);
    chk("glitch8_recover", 32'(rst_sys_n), 32'd1);

    // Held request keeps reset asserted; release follows filter clear
    bad = 0;
    req_n[0] = 1'b0;
    repeat (100) step();
    for (int i = 0; i < 100; i++) begin
      step();
      if (rst_sys_n !== 1'b0) bad++;
    end
    chk("held_release_early", 32'(bad), 32'd0);
    req_n[0] = 1'b1;
    wait_rst(1'b1, 200, n);
    chk("held_latency", 32'(n), 32'd52);

    // Strap bounce during sampling, then settle on 10
    strap = 2'b10;
    req_n[2] = 1'b0;
    repeat (10) step();
    req_n[2] = 1'b1;
    bad = 0;
    for (int k = 0; k < 11; k++) begin
      strap[0] = ~strap[0];
      repeat (10) begin step(); if (rst_sys_n !== 1'b0) bad++; end
    end
    chk("bounce_early_latch", 32'(bad), 32'd0);
    strap = 2'b10;
    wait_rst(1'b1, 100, n);
    chk("bounce_latency", 32'(n), 32'd19);
    chk("bounce_strap", 32'(strap_out), 32'h2);
    chk("bounce_dbg_sel", 32'(dbg_spi_sel), 32'd0);

    // Strap pins ignored once locked
    strap = 2'b11;
    repeat (40) step();
    chk("lock_strap", 32'(strap_out), 32'h2);
    chk("lock_valid", 32'(strap_valid), 32'd1);

`ifdef STRAP_RST_CAUSE_EN
    req_n = 3'b010;
    wait_rst(1'b0, 30, n);
    chk("cause_multi", 32'(rst_cause), 32'h5);
    chk("cause_por_clr", 32'(por), 32'd0);
    req_n = '1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("cause_after_rst", 32'(rst_cause), 32'h0);
    chk("por_after_rst", 32'(por), 32'd1);
`endif

    // Randomized pads, straps and occasional synchronous resets
    for (int i = 0; i < NSRC; i++) pulse_left[i] = 0;
    for (int c = 0; c < 6000; c++) begin
      step();
      rst = ($urandom_range(0, 799) == 0);
      for (int i = 0; i < NSRC; i++) begin
        if (pulse_left[i] > 0) begin
          req_n[i] = 1'b0;
          pulse_left[i]--;
        end else begin
          req_n[i] = 1'b1;
          if ($urandom_range(0, 299) == 0) pulse_left[i] = int'($urandom_range(1, 14));
        end
      end
      if ($urandom_range(0, 39) == 0) strap = NSTR'($urandom);
    end
    rst = 1'b0; req_n = '1;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
